// File: rtl/memory_stage.sv
// Pipeline memory stage: holds the MEM stage registers, issues data-memory
// requests for LD/ST/LDR, stalls the pipeline until ready, feeds write-back.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ir_src_mem,
    input  logic [31:0] pc_mem_next,
    input  logic [31:0] ir_mem_next,
    input  logic [31:0] y_mem_next,
    input  logic [31:0] st_mem_next,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall_mem,
    output logic [31:0] pc_wb_next,
    output logic [31:0] ir_wb_next,
    output logic [31:0] y_wb_next,
    output logic [31:0] y_mem_fwd,
    output logic [31:0] ir_mem_fwd
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_LD  = 6'b011000;
    localparam logic [OPW-1:0] OP_ST  = 6'b011001;
    localparam logic [OPW-1:0] OP_LDR = 6'b011111;

    localparam logic [XLEN-1:0] INST_NOP        = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BNE_EXCEPT = 32'h1400_FFFF;

    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd1;
    localparam logic [1:0] IR_SRC_NOP    = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_mem;
    logic [XLEN-1:0] ir_mem;
    logic [XLEN-1:0] y_mem;
    logic [XLEN-1:0] st_mem;
    logic [OPW-1:0]  opcode;
    logic            mem_op;
    logic            is_st;
    logic            is_ld;

    assign opcode = ir_mem[XLEN-1:XLEN-OPW];
    assign mem_op = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_LDR);
    assign is_st  = (opcode == OP_ST);
    assign is_ld  = (opcode == OP_LD) || (opcode == OP_LDR);

    // Stage registers; holding them while stalled keeps the request stable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mem <= '0;
            ir_mem <= INST_NOP;
            y_mem  <= '0;
            st_mem <= '0;
        end else if (!stall_mem) begin
            pc_mem <= pc_mem_next;
            ir_mem <= ir_mem_next;
            y_mem  <= y_mem_next;
            st_mem <= st_mem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                dmem_req = mem_op;
                dmem_we  = mem_op & is_st;
                if (mem_op && !dmem_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign stall_mem  = dmem_req & ~dmem_ready;
    assign dmem_addr  = {y_mem[XLEN-1:2], 2'b00};
    assign dmem_wdata = st_mem;

    assign pc_wb_next = pc_mem;
    assign y_wb_next  = (dmem_req && dmem_ready && is_ld) ? dmem_rdata : y_mem;

    // Write-back sees a bubble while the access is pending
    always_comb begin
        ir_wb_next = INST_NOP;
        if (!stall_mem) begin
            case (ir_src_mem)
                IR_SRC_EXCEPT: ir_wb_next = INST_BNE_EXCEPT;
                IR_SRC_NOP:    ir_wb_next = INST_NOP;
                IR_SRC_DATA:   ir_wb_next = ir_mem;
                default:       ir_wb_next = INST_NOP;
            endcase
        end
    end

    assign y_mem_fwd  = y_mem;
    assign ir_mem_fwd = ir_mem;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, zero-wait load, waited
// store, back-to-back loads, reset during a pending access, IR source select.
module tb_memory_stage;

    localparam logic [31:0] INST_NOP        = 32'h0000_0000;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h1400_FFFF;
    localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
    localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd1;
    localparam logic [1:0]  IR_SRC_NOP      = 2'd2;

    localparam logic [31:0] I_ADD  = 32'h0085_1820;
    localparam logic [31:0] I_ADD2 = 32'h00A6_2020;
    localparam logic [31:0] I_LD   = 32'h6022_0004;
    localparam logic [31:0] I_LD2  = 32'h6044_0008;
    localparam logic [31:0] I_ST   = 32'h6443_0000;
    localparam logic [31:0] I_LDR  = 32'h7C01_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ir_src_mem;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_req, dmem_we, stall_mem;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, y_mem_fwd, ir_mem_fwd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .ir_src_mem(ir_src_mem),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .stall_mem(stall_mem), .pc_wb_next(pc_wb_next),
        .ir_wb_next(ir_wb_next), .y_wb_next(y_wb_next),
        .y_mem_fwd(y_mem_fwd), .ir_mem_fwd(ir_mem_fwd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] ir,
                        input logic [31:0] y, input logic [31:0] st);
        pc_mem_next = pc;
        ir_mem_next = ir;
        y_mem_next  = y;
        st_mem_next = st;
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ir_src_mem = IR_SRC_DATA;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_req",   32'(dmem_req), 32'd0);
        check("rst_we",    32'(dmem_we), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        check("rst_addr",  dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_pc_wb", pc_wb_next, 32'h0);
        check("rst_y_wb",  y_wb_next, 32'h0);
        check("rst_ir_wb", ir_wb_next, INST_NOP);

        // ALU instruction passes straight through
        feed(32'h100, I_ADD, 32'h10, 32'h0);
        tick();
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        #1;
        check("add_req",   32'(dmem_req), 32'd0);
        check("add_stall", 32'(stall_mem), 32'd0);
        check("add_y_wb",  y_wb_next, 32'h10);
        check("add_ir_wb", ir_wb_next, I_ADD);
        check("add_pc_wb", pc_wb_next, 32'h100);

        // Zero-wait load
        feed(32'h104, I_LD, 32'h104, 32'h0);
        tick();
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_req",   32'(dmem_req), 32'd1);
        check("ld_addr",  dmem_addr, 32'h104);
        check("ld_we",    32'(dmem_we), 32'd0);
        check("ld_stall", 32'(stall_mem), 32'd0);
        check("ld_y_wb",  y_wb_next, 32'hDEAD_BEEF);
        check("ld_ir_wb", ir_wb_next, I_LD);
        tick();
        #1;
        check("ld_ready_idle_req", 32'(dmem_req), 32'd0);
        check("ld_ready_idle_y",   y_wb_next, 32'h0);
        dmem_ready = 1'b0;

        // Store with three wait cycles, misaligned address
        feed(32'h200, I_ST, 32'h203, 32'h1234_5678);
        tick();
        feed(32'h204, I_ADD2, 32'h55, 32'h0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("st_wait_addr",  dmem_addr, 32'h200);
            check("st_wait_we",    32'(dmem_we), 32'd1);
            check("st_wait_wdata", dmem_wdata, 32'h1234_5678);
            check("st_wait_stall", 32'(stall_mem), 32'd1);
            check("st_wait_ir_wb", ir_wb_next, INST_NOP);
            tick();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE_0000;
        #1;
        check("st_rdy_addr",  dmem_addr, 32'h200);
        check("st_rdy_we",    32'(dmem_we), 32'd1);
        check("st_rdy_wdata", dmem_wdata, 32'h1234_5678);
        check("st_rdy_stall", 32'(stall_mem), 32'd0);
        check("st_rdy_ir_wb", ir_wb_next, I_ST);
        check("st_rdy_y_wb",  y_wb_next, 32'h203);
        tick();
        dmem_ready = 1'b0;
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        #1;
        check("st_after_req",   32'(dmem_req), 32'd0);
        check("st_after_ir_wb", ir_wb_next, I_ADD2);
        check("st_after_y_wb",  y_wb_next, 32'h55);
        check("st_after_pc_wb", pc_wb_next, 32'h204);

        // LDR then LD, one wait each
        feed(32'h300, I_LDR, 32'h300, 32'h0);
        tick();
        feed(32'h304, I_LD2, 32'h404, 32'h0);
        #1;
        check("ldr_w_req",   32'(dmem_req), 32'd1);
        check("ldr_w_addr",  dmem_addr, 32'h300);
        check("ldr_w_stall", 32'(stall_mem), 32'd1);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hAAAA_0001;
        #1;
        check("ldr_r_addr",  dmem_addr, 32'h300);
        check("ldr_r_stall", 32'(stall_mem), 32'd0);
        check("ldr_r_y_wb",  y_wb_next, 32'hAAAA_0001);
        tick();
        dmem_ready = 1'b0;
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        #1;
        check("ld2_w_req",   32'(dmem_req), 32'd1);
        check("ld2_w_addr",  dmem_addr, 32'h404);
        check("ld2_w_stall", 32'(stall_mem), 32'd1);
        check("ld2_w_ir_wb", ir_wb_next, INST_NOP);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hBBBB_0002;
        #1;
        check("ld2_r_addr",  dmem_addr, 32'h404);
        check("ld2_r_y_wb",  y_wb_next, 32'hBBBB_0002);
        check("ld2_r_ir_wb", ir_wb_next, I_LD2);
        tick();
        dmem_ready = 1'b0;
        #1;
        check("ld2_after_req", 32'(dmem_req), 32'd0);

        // Reset while waiting abandons the access
        feed(32'h500, I_LD, 32'h500, 32'h0);
        tick();
        feed(32'h0, INST_NOP, 32'h0, 32'h0);
        tick();
        check("rstw_req",   32'(dmem_req), 32'd1);
        check("rstw_stall", 32'(stall_mem), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h7777_7777;
        #1;
        check("rstw_after_req",   32'(dmem_req), 32'd0);
        check("rstw_after_stall", 32'(stall_mem), 32'd0);
        check("rstw_after_ir_wb", ir_wb_next, INST_NOP);
        check("rstw_after_y_wb",  y_wb_next, 32'h0);
        check("rstw_after_addr",  dmem_addr, 32'h0);
        tick();
        dmem_ready = 1'b0;
        #1;
        check("rstw_late_req", 32'(dmem_req), 32'd0);

        // IR source select with a non-memory instruction
        feed(32'h700, I_ADD, 32'h9, 32'h0);
        tick();
        ir_src_mem = IR_SRC_EXCEPT;
        #1;
        check("exc_ir_wb", ir_wb_next, INST_BNE_EXCEPT);
        check("exc_pc_wb", pc_wb_next, 32'h700);
        ir_src_mem = IR_SRC_NOP;
        #1;
        check("nop_ir_wb", ir_wb_next, INST_NOP);
        ir_src_mem = 2'd3;
        #1;
        check("bad_src_ir_wb", ir_wb_next, INST_NOP);
        ir_src_mem = IR_SRC_DATA;
        #1;
        check("data_ir_wb", ir_wb_next, I_ADD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
